// File: rtl/sha256_compress_par.sv
// rtl/sha256_compress_par.sv - SHA-256 compression core, ROUNDS_PER_CYCLE rounds unrolled per clock
module sha256_compress_par #(
  parameter int ROUNDS_PER_CYCLE = 1
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [511:0] chunk,
  input  logic [255:0] state_in,
  input  logic         use_iv,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [255:0] state_out,
  output logic         busy
);
  localparam int R = ROUNDS_PER_CYCLE;
  localparam int CYCLES = 64 / R;
  localparam logic [5:0] LAST = 6'(CYCLES - 1);
  localparam logic [255:0] IV =
    256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
  localparam logic [31:0] K [0:63] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  generate
    if (R != 1 && R != 2 && R != 4 && R != 8 && R != 16) begin : g_bad_r
      $error("sha256_compress_par: ROUNDS_PER_CYCLE must be 1, 2, 4, 8 or 16");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, ROUND, DONE} state_t;
  state_t state, state_nx;

  logic        started;
  logic        accept;
  logic [5:0]  cnt;
  logic [5:0]  kidx;
  logic [31:0] hv [0:7];
  logic [31:0] wv [0:7];
  logic [31:0] vn [0:7];
  logic [31:0] win [0:15];
  logic [31:0] ext [0:15+R];
  logic [31:0] t1, t2;
  logic [255:0] h_src;

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction
  function automatic logic [31:0] big_sig0(input logic [31:0] x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction
  function automatic logic [31:0] big_sig1(input logic [31:0] x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction
  function automatic logic [31:0] small_sig0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction
  function automatic logic [31:0] small_sig1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  // in_ready is held low until the first edge after reset release
  assign in_ready = started && (state == IDLE);
  assign busy     = (state != IDLE);
  assign accept   = in_valid && in_ready;
  assign h_src    = use_iv ? IV : state_in;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept) state_nx = ROUND;
      ROUND:   if (cnt == LAST) state_nx = DONE;
      DONE:    if (out_valid && out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // ext[0..15] is the window; ext[16..15+R] are the words the next R rounds push in
  always_comb begin
    t1   = '0;
    t2   = '0;
    kidx = '0;
    for (int i = 0; i < 16; i++) ext[i] = win[i];
    for (int k = 0; k < R; k++)
      ext[16+k] = small_sig1(ext[14+k]) + ext[9+k] + small_sig0(ext[1+k]) + ext[k];
    for (int i = 0; i < 8; i++) vn[i] = wv[i];
    for (int k = 0; k < R; k++) begin
      kidx  = 6'(32'(cnt) * 32'(R) + 32'(k));
      t1    = vn[7] + big_sig1(vn[4]) + ((vn[4] & vn[5]) ^ (~vn[4] & vn[6])) + K[kidx] + ext[k];
      t2    = big_sig0(vn[0]) + ((vn[0] & vn[1]) ^ (vn[0] & vn[2]) ^ (vn[1] & vn[2]));
      vn[7] = vn[6];
      vn[6] = vn[5];
      vn[5] = vn[4];
      vn[4] = vn[3] + t1;
      vn[3] = vn[2];
      vn[2] = vn[1];
      vn[1] = vn[0];
      vn[0] = t1 + t2;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      started   <= 1'b0;
      cnt       <= '0;
      out_valid <= 1'b0;
      state_out <= '0;
      for (int i = 0; i < 8; i++) begin
        hv[i] <= '0;
        wv[i] <= '0;
      end
      for (int i = 0; i < 16; i++) win[i] <= '0;
    end else begin
      started <= 1'b1;
      if (accept) begin
        for (int i = 0; i < 8; i++) begin
          hv[i] <= h_src[255-32*i -: 32];
          wv[i] <= h_src[255-32*i -: 32];
        end
        for (int i = 0; i < 16; i++) win[i] <= chunk[511-32*i -: 32];
        cnt <= '0;
      end else if (state == ROUND) begin
        for (int i = 0; i < 8; i++) wv[i] <= vn[i];
        for (int i = 0; i < 16; i++) win[i] <= ext[i+R];
        cnt <= cnt + 6'd1;
        if (cnt == LAST) begin
          for (int i = 0; i < 8; i++) state_out[255-32*i -: 32] <= hv[i] + vn[i];
          out_valid <= 1'b1;
        end
      end else if (state == DONE && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_sha256_compress_par.sv
// tb/tb_sha256_compress_par.sv - random and known-answer checks of sha256_compress_par for every legal R
module tb_sha256_compress_par;
  localparam int NI = 5;
  localparam logic [255:0] IV =
    256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
  localparam logic [511:0] BLK_ABC   = {32'h61626380, 448'h0, 32'h00000018};
  localparam logic [511:0] BLK_EMPTY = {32'h80000000, 480'h0};
  localparam logic [255:0] DIG_ABC =
    256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  localparam logic [255:0] DIG_EMPTY =
    256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
  localparam logic [511:0] BLK_2A = {
    32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667, 32'h65666768, 32'h66676869,
    32'h6768696a, 32'h68696a6b, 32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
    32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
  localparam logic [511:0] BLK_2B = {480'h0, 32'h000001c0};
  localparam logic [255:0] DIG_2 =
    256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;
  localparam logic [31:0] KT [0:63] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic [511:0] chunk = '0;
  logic [255:0] state_in = '0;
  logic         use_iv = 1'b0;
  logic [NI-1:0] in_ready_v, out_valid_v, busy_v;
  logic [255:0]  state_out_v [NI];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < NI; gi++) begin : g_dut
    sha256_compress_par #(.ROUNDS_PER_CYCLE(1 << gi)) u_dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready_v[gi]),
      .chunk     (chunk),
      .state_in  (state_in),
      .use_iv    (use_iv),
      .out_valid (out_valid_v[gi]),
      .out_ready (out_ready),
      .state_out (state_out_v[gi]),
      .busy      (busy_v[gi])
    );
  end

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ror(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  // Textbook FIPS 180-4 compression with a full 64-word schedule
  function automatic logic [255:0] ref_compress(input logic [511:0] blk, input logic [255:0] hin);
    logic [31:0] w [64];
    logic [31:0] v [8];
    logic [31:0] s0, s1, t1, t2;
    logic [255:0] res;
    for (int t = 0; t < 16; t++) w[t] = blk[511-32*t -: 32];
    for (int t = 16; t < 64; t++) begin
      s0 = ror(w[t-15], 7) ^ ror(w[t-15], 18) ^ (w[t-15] >> 3);
      s1 = ror(w[t-2], 17) ^ ror(w[t-2], 19) ^ (w[t-2] >> 10);
      w[t] = s1 + w[t-7] + s0 + w[t-16];
    end
    for (int i = 0; i < 8; i++) v[i] = hin[255-32*i -: 32];
    for (int t = 0; t < 64; t++) begin
      t1 = v[7] + (ror(v[4], 6) ^ ror(v[4], 11) ^ ror(v[4], 25)) + ((v[4] & v[5]) ^ (~v[4] & v[6]))
           + KT[t] + w[t];
      t2 = (ror(v[0], 2) ^ ror(v[0], 13) ^ ror(v[0], 22)) + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
      v[7] = v[6]; v[6] = v[5]; v[5] = v[4]; v[4] = v[3] + t1;
      v[3] = v[2]; v[2] = v[1]; v[1] = v[0]; v[0] = t1 + t2;
    end
    for (int i = 0; i < 8; i++) res[255-32*i -: 32] = hin[255-32*i -: 32] + v[i];
    return res;
  endfunction

  function automatic logic [511:0] rand_blk();
    logic [511:0] b;
    for (int i = 0; i < 16; i++) b[32*i +: 32] = $urandom;
    return b;
  endfunction

  task automatic start_block(input logic [511:0] blk, input logic [255:0] st, input logic iv);
    @(negedge clk);
    chunk = blk; state_in = st; use_iv = iv; in_valid = 1'b1;
    for (int i = 0; i < NI; i++) check($sformatf("in_ready_idle_r%0d", 1 << i), 256'(in_ready_v[i]), 256'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0; chunk = rand_blk(); state_in = {rand_blk()}[255:0]; use_iv = $urandom_range(0, 1);
  endtask

  // Called right after the accept edge; ends on a negedge with every instance in DONE
  task automatic wait_done(input logic [255:0] exp, input bit early_ready);
    int first [NI];
    for (int i = 0; i < NI; i++) first[i] = -1;
    out_ready = early_ready;
    for (int c = 0; c < 70; c++) begin
      @(negedge clk);
      if (c == 2) out_ready = 1'b0;
      for (int i = 0; i < NI; i++)
        if (out_valid_v[i] && first[i] < 0) first[i] = c;
    end
    for (int i = 0; i < NI; i++) begin
      check($sformatf("latency_r%0d", 1 << i), 256'(first[i]), 256'(64 >> i));
      check($sformatf("digest_r%0d", 1 << i), state_out_v[i], exp);
      check($sformatf("busy_done_r%0d", 1 << i), 256'(busy_v[i]), 256'd1);
      check($sformatf("in_ready_done_r%0d", 1 << i), 256'(in_ready_v[i]), 256'd0);
    end
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    for (int i = 0; i < NI; i++) begin
      check($sformatf("out_valid_clr_r%0d", 1 << i), 256'(out_valid_v[i]), 256'd0);
      check($sformatf("in_ready_back_r%0d", 1 << i), 256'(in_ready_v[i]), 256'd1);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [511:0] blk;
    logic [255:0] st, exp, mid;
    logic         iv;
    int           stale;

    repeat (3) @(negedge clk);
    for (int i = 0; i < NI; i++) begin
      check($sformatf("rst_out_valid_r%0d", 1 << i), 256'(out_valid_v[i]), 256'd0);
      check($sformatf("rst_busy_r%0d", 1 << i), 256'(busy_v[i]), 256'd0);
      check($sformatf("rst_state_out_r%0d", 1 << i), state_out_v[i], 256'd0);
      check($sformatf("rst_in_ready_r%0d", 1 << i), 256'(in_ready_v[i]), 256'd0);
    end
    reset_n = 1'b1;
    @(negedge clk);
    check("in_ready_after_release", 256'(in_ready_v[0]), 256'd1);

    start_block(BLK_ABC, '0, 1'b1);
    wait_done(DIG_ABC, 1'b0);
    release_out();

    start_block(BLK_EMPTY, {rand_blk()}[255:0], 1'b1);
    wait_done(DIG_EMPTY, 1'b1);
    release_out();

    start_block(BLK_2A, '0, 1'b1);
    wait_done(ref_compress(BLK_2A, IV), 1'b0);
    mid = state_out_v[0];
    release_out();
    start_block(BLK_2B, mid, 1'b0);
    wait_done(DIG_2, 1'b0);
    release_out();

    for (int n = 0; n < 6; n++) begin
      blk = rand_blk();
      st  = {rand_blk()}[255:0];
      iv  = $urandom_range(0, 1);
      exp = ref_compress(blk, iv ? IV : st);
      start_block(blk, st, iv);
      wait_done(exp, bit'($urandom_range(0, 1)));
      release_out();
    end

    // Backpressure: result must hold while the next block waits on in_valid
    start_block(BLK_ABC, '0, 1'b1);
    wait_done(DIG_ABC, 1'b0);
    chunk = BLK_EMPTY; use_iv = 1'b1; in_valid = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      check("hold_state_out", state_out_v[0], DIG_ABC);
      check("hold_out_valid", 256'(out_valid_v[0]), 256'd1);
      check("hold_in_ready", 256'(in_ready_v[0]), 256'd0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("bp_in_ready_after", 256'(in_ready_v[0]), 256'd1);
    check("bp_out_valid_after", 256'(out_valid_v[0]), 256'd0);
    @(posedge clk);
    #1;
    in_valid = 1'b0; chunk = rand_blk();
    wait_done(DIG_EMPTY, 1'b0);
    release_out();

    // Reset in the middle of the R=1 computation
    start_block(BLK_ABC, '0, 1'b1);
    repeat (30) @(negedge clk);
    reset_n = 1'b0;
    #1;
    for (int i = 0; i < NI; i++) begin
      check($sformatf("midrst_out_valid_r%0d", 1 << i), 256'(out_valid_v[i]), 256'd0);
      check($sformatf("midrst_state_out_r%0d", 1 << i), state_out_v[i], 256'd0);
      check($sformatf("midrst_busy_r%0d", 1 << i), 256'(busy_v[i]), 256'd0);
    end
    @(negedge clk);
    reset_n = 1'b1;
    stale = 0;
    for (int c = 0; c < 70; c++) begin
      @(negedge clk);
      if (out_valid_v != '0) stale++;
    end
    check("no_stale_out_valid", 256'(stale), 256'd0);
    start_block(BLK_ABC, '0, 1'b1);
    wait_done(DIG_ABC, 1'b0);
    release_out();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
